cmpt_dcd_pipe: RTL and testbench

- Parametrised, pipelined successor to the compute-field instruction decoder.
- Decodes the compute field into ALU, MUL and SHF control signals, register-file read addresses and a writeback address.
- Adds a valid/ready handshake, a registered decode stage and a WB_LAT-deep write scoreboard. The scoreboard stalls issue on read-after-write hazards and produces delayed register-file write enables.
- Sits between the instruction sequencer and the compute units and register-file crossbar.

---
 rtl/cmpt_dcd_pipe.sv | 192 +++++++++++++++++++
 tb/tb_cmpt_dcd_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmpt_dcd_pipe.sv
// Compute-field decoder with a registered decode stage and a WB_LAT-deep write scoreboard.
// Latency: 1 cycle to decode outputs, WB_LAT cycles from accept to rf_we. Build option CMPT_DCD_FWD_EN forwards from the last stage.
// Backpressure: in_rdy drops combinationally on a read-after-write hazard or flush.
module cmpt_dcd_pipe #(
    parameter int RF_AW  = 4,
    parameter int WB_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [8+3*RF_AW:0]  in_instr,
    input  logic                in_float,
    input  logic                flush,
    output logic                dec_vld,
    output logic                alu_en,
    output logic                mul_en,
    output logic                shf_en,
    output logic                cu_float,
    output logic [1:0]          cls,
    output logic                mode,
    output logic [3:0]          subop,
    output logic [RF_AW-1:0]    rd_a,
    output logic [RF_AW-1:0]    rd_b,
    output logic [2:0]          rf_we,
    output logic [RF_AW-1:0]    rf_wa,
    output logic                fwd_a,
    output logic                fwd_b
);
    localparam int B = 3 * RF_AW;

    localparam logic [2:0] U_ALU = 3'b001;
    localparam logic [2:0] U_MUL = 3'b010;
    localparam logic [2:0] U_SHF = 3'b100;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MUL = 2'b01,
        SEL_SHF = 2'b10,
        SEL_NOP = 2'b11
    } sel_e;

    sel_e             sel;
    logic [1:0]       f_cls;
    logic             f_mode;
    logic [3:0]       f_subop;
    logic [RF_AW-1:0] f_rd;
    logic [RF_AW-1:0] f_ra;
    logic [RF_AW-1:0] f_rb;

    assign sel     = sel_e'(in_instr[B+8:B+7]);
    assign f_cls   = in_instr[B+6:B+5];
    assign f_mode  = in_instr[B+4];
    assign f_subop = in_instr[B+3:B];
    assign f_rd    = in_instr[B-1:2*RF_AW];
    assign f_ra    = in_instr[2*RF_AW-1:RF_AW];
    assign f_rb    = in_instr[RF_AW-1:0];

    logic       ua;
    logic       ub;
    logic       wr;
    logic [2:0] unit;

    always_comb begin
        ua   = 1'b0;
        ub   = 1'b0;
        wr   = 1'b0;
        unit = 3'b000;
        case (sel)
            SEL_ALU: begin
                ua   = 1'b1;
                ub   = !f_mode;
                // compare forms (cls[1]=0, subop[2]=subop[0]=1) only set flags
                wr   = !(!f_cls[1] && f_subop[0] && f_subop[2]);
                unit = U_ALU;
            end
            SEL_MUL: begin
                ua   = (f_cls != 2'b00) || (f_mode && (f_subop[1:0] != 2'b11));
                ub   = (f_cls != 2'b00);
                wr   = !f_mode;
                unit = U_MUL;
            end
            SEL_SHF: begin
                ua   = 1'b1;
                ub   = !f_mode;
                wr   = 1'b1;
                unit = U_SHF;
            end
            default: begin
                ua   = 1'b0;
                ub   = 1'b0;
                wr   = 1'b0;
                unit = 3'b000;
            end
        endcase
    end

    logic [WB_LAT-1:0]            sb_v;
    logic [WB_LAT-1:0][2:0]       sb_u;
    logic [WB_LAT-1:0][RF_AW-1:0] sb_a;
    logic [WB_LAT-1:0]            m_a;
    logic [WB_LAT-1:0]            m_b;
    logic                         stall;
    logic                         accept;

    always_comb begin
        m_a = '0;
        m_b = '0;
        for (int k = 0; k < WB_LAT; k++) begin
            m_a[k] = sb_v[k] && ua && (sb_a[k] == f_ra);
            m_b[k] = sb_v[k] && ub && (sb_a[k] == f_rb);
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < WB_LAT; k++) begin
`ifdef CMPT_DCD_FWD_EN
            // the last stage is writing this cycle, so its value can be bypassed
            if (k != WB_LAT - 1)
`endif
                stall = stall | m_a[k] | m_b[k];
        end
    end

    assign in_rdy = !stall && !flush;
    assign accept = in_vld && in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_vld  <= 1'b0;
            alu_en   <= 1'b0;
            mul_en   <= 1'b0;
            shf_en   <= 1'b0;
            cu_float <= 1'b0;
            cls      <= 2'b00;
            mode     <= 1'b0;
            subop    <= 4'b0000;
            rd_a     <= '0;
            rd_b     <= '0;
        end else begin
            dec_vld <= accept;
            if (accept) begin
                alu_en   <= (sel == SEL_ALU);
                mul_en   <= (sel == SEL_MUL);
                shf_en   <= (sel == SEL_SHF);
                cu_float <= in_float;
                cls      <= f_cls;
                mode     <= f_mode;
                subop    <= f_subop;
                rd_a     <= ua ? f_ra : '0;
                rd_b     <= ub ? f_rb : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v <= '0;
            sb_u <= '0;
            sb_a <= '0;
        end else begin
            sb_v[0] <= accept && wr;
            sb_u[0] <= (accept && wr) ? unit : 3'b000;
            sb_a[0] <= (accept && wr) ? f_rd : '0;
            for (int k = 1; k < WB_LAT; k++) begin
                sb_v[k] <= sb_v[k-1];
                sb_u[k] <= sb_u[k-1];
                sb_a[k] <= sb_a[k-1];
            end
        end
    end

    assign rf_we = sb_v[WB_LAT-1] ? sb_u[WB_LAT-1] : 3'b000;
    assign rf_wa = sb_v[WB_LAT-1] ? sb_a[WB_LAT-1] : '0;

`ifdef CMPT_DCD_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
        end else if (accept) begin
            fwd_a <= m_a[WB_LAT-1];
            fwd_b <= m_b[WB_LAT-1];
        end
    end
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

endmodule

// File: tb/tb_cmpt_dcd_pipe.sv
// Self-checking bench for cmpt_dcd_pipe: directed scenarios plus random traffic against a cycle-numbered write-list model.
module tb_cmpt_dcd_pipe;
    localparam int RF_AW  = 4;
    localparam int WB_LAT = 2;
    localparam int IW     = 9 + 3 * RF_AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [IW-1:0] in_instr;
    logic          in_float;
    logic          flush;
    logic          dec_vld, alu_en, mul_en, shf_en, cu_float, mode, fwd_a, fwd_b;
    logic [1:0]    cls;
    logic [3:0]    subop;
    logic [3:0]    rd_a, rd_b, rf_wa;
    logic [2:0]    rf_we;

    always #5 clk = ~clk;

    cmpt_dcd_pipe #(.RF_AW(RF_AW), .WB_LAT(WB_LAT)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_instr(in_instr),
        .in_float(in_float), .flush(flush), .dec_vld(dec_vld), .alu_en(alu_en),
        .mul_en(mul_en), .shf_en(shf_en), .cu_float(cu_float), .cls(cls), .mode(mode),
        .subop(subop), .rd_a(rd_a), .rd_b(rd_b), .rf_we(rf_we), .rf_wa(rf_wa),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // a pending register write, retired in the cycle numbered 'due'
    typedef struct {
        int due;
        int unit;
        int addr;
    } wr_t;
    wr_t pend[$];

    logic       e_dec, e_alu, e_mul, e_shf, e_flt, e_mode, e_fa, e_fb;
    logic [1:0] e_cls;
    logic [3:0] e_sub, e_rda, e_rdb, e_wa;
    logic [2:0] e_we;
    logic       obs_rdy, exp_rdy;

    function automatic logic [IW-1:0] mk(int s, int c, int m, int su, int d, int a, int b);
        return IW'((s << 19) | (c << 17) | (m << 16) | (su << 12) | (d << 8) | (a << 4) | b);
    endfunction

    function automatic logic [28:0] obs_vec();
        return {dec_vld, alu_en, mul_en, shf_en, cu_float, cls, mode, subop,
                rd_a, rd_b, rf_we, rf_wa, fwd_a, fwd_b};
    endfunction

    function automatic logic [28:0] exp_vec();
        return {e_dec, e_alu, e_mul, e_shf, e_flt, e_cls, e_mode, e_sub,
                e_rda, e_rdb, e_we, e_wa, e_fa, e_fb};
    endfunction

    task automatic model_clear();
        pend.delete();
        {e_dec, e_alu, e_mul, e_shf, e_flt, e_mode, e_fa, e_fb} = '0;
        e_cls = '0; e_sub = '0; e_rda = '0; e_rdb = '0; e_wa = '0; e_we = '0;
    endtask

    // One clock: predict in_rdy at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int  v, s, c, m, su, d, a, b;
        bit  ua, ub, wr, is_cmp, haz, fa, fb, acc;
        @(negedge clk);
        v  = int'(in_instr);
        s  = (v >> 19) & 3;  c = (v >> 17) & 3;  m = (v >> 16) & 1;  su = (v >> 12) & 15;
        d  = (v >> 8) & 15;  a = (v >> 4) & 15;  b = v & 15;
        ua = (s == 0) || (s == 2) || (s == 1 && (c != 0 || (m == 1 && (su % 4) != 3)));
        ub = ((s == 0 || s == 2) && m == 0) || (s == 1 && c != 0);
        is_cmp = (s == 0) && (c < 2) && (su % 2 == 1) && ((su / 4) % 2 == 1);
        wr = (s == 0 && !is_cmp) || (s == 1 && m == 0) || (s == 2);
        haz = 0; fa = 0; fb = 0;
        foreach (pend[i]) begin
            if (pend[i].due >= cyc) begin
`ifdef CMPT_DCD_FWD_EN
                if (pend[i].due == cyc) begin
                    fa = fa | (ua && pend[i].addr == a);
                    fb = fb | (ub && pend[i].addr == b);
                end else
`endif
                    haz = haz | (ua && pend[i].addr == a) | (ub && pend[i].addr == b);
            end
        end
        exp_rdy = !haz && !flush;
        obs_rdy = in_rdy;
        acc = in_vld && exp_rdy;
        @(posedge clk);
        if (acc) begin
            e_dec = 1; e_alu = (s == 0); e_mul = (s == 1); e_shf = (s == 2); e_flt = in_float;
            e_cls = 2'(c); e_mode = m[0]; e_sub = 4'(su);
            e_rda = ua ? 4'(a) : 4'd0;
            e_rdb = ub ? 4'(b) : 4'd0;
            e_fa = fa; e_fb = fb;
            if (wr) pend.push_back('{cyc + WB_LAT, (s == 0) ? 1 : (s == 1) ? 2 : 4, d});
        end else begin
            e_dec = 0;
        end
        cyc++;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        e_we = '0; e_wa = '0;
        foreach (pend[i]) if (pend[i].due == cyc) begin
            e_we = 3'(pend[i].unit);
            e_wa = 4'(pend[i].addr);
        end
        #1;
    endtask

    task automatic idle(int n);
        in_vld = 0; flush = 0;
        repeat (n) tick();
    endtask

    task automatic test_reset_state();
        rst = 1; in_vld = 0; flush = 0; in_float = 0; in_instr = '0;
        model_clear();
        #3;
        n_tests++;
        if (obs_vec() !== 29'd0) begin n_fail++; $display("FAIL reset_state: got %h want 0", obs_vec()); end
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", in_rdy); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_alu();
        idle(4);
        in_vld = 1; in_float = 0; in_instr = mk(0, 0, 0, 0, 3, 1, 2);
        tick();
        n_tests++;
        if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL alu_rdy: got %b want 1", obs_rdy); end
        n_tests++;
        if ({dec_vld, alu_en, mul_en, shf_en, rd_a, rd_b} !== {4'b1100, 4'd1, 4'd2}) begin
            n_fail++; $display("FAIL alu_dec: got %b%b%b%b rd_a=%0d rd_b=%0d want 1100 1 2",
                               dec_vld, alu_en, mul_en, shf_en, rd_a, rd_b);
        end
        in_vld = 0;
        tick();
        n_tests++;
        if ({rf_we, rf_wa} !== {3'b001, 4'd3}) begin
            n_fail++; $display("FAIL alu_wb: got we=%b wa=%0d want 001 3", rf_we, rf_wa);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL alu_all: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_dependent();
        int stalls, exp_stalls;
        bit accepted;
        logic exp_fa;
`ifdef CMPT_DCD_FWD_EN
        exp_stalls = 1; exp_fa = 1'b1;
`else
        exp_stalls = 2; exp_fa = 1'b0;
`endif
        idle(4);
        in_vld = 1; in_instr = mk(0, 0, 0, 0, 3, 1, 2);
        tick();
        in_instr = mk(0, 0, 0, 0, 5, 3, 4);
        stalls = 0; accepted = 0;
        for (int i = 0; i < 6 && !accepted; i++) begin
            tick();
            n_tests++;
            if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL dep_rdy: got %b want %b", obs_rdy, exp_rdy); end
            if (obs_rdy === 1'b1) accepted = 1; else stalls++;
        end
        in_vld = 0;
        n_tests++;
        if (!accepted || stalls != exp_stalls) begin
            n_fail++; $display("FAIL dep_stalls: got %0d (accepted=%0b) want %0d", stalls, accepted, exp_stalls);
        end
        n_tests++;
        if ({dec_vld, rd_a, rd_b, fwd_a} !== {1'b1, 4'd3, 4'd4, exp_fa}) begin
            n_fail++; $display("FAIL dep_dec: got vld=%b rd_a=%0d rd_b=%0d fwd_a=%b want 1 3 4 %b",
                               dec_vld, rd_a, rd_b, fwd_a, exp_fa);
        end
        tick();
        n_tests++;
        if ({rf_we, rf_wa} !== {3'b001, 4'd5}) begin
            n_fail++; $display("FAIL dep_wb: got we=%b wa=%0d want 001 5", rf_we, rf_wa);
        end
    endtask

    task automatic test_mul_noread();
        idle(4);
        in_vld = 1; in_instr = mk(1, 0, 1, 3, 3, 1, 2);
        tick();
        in_vld = 0;
        n_tests++;
        if ({dec_vld, alu_en, mul_en, shf_en, rd_a, rd_b} !== {4'b1010, 8'd0}) begin
            n_fail++; $display("FAIL mul_dec: got %b%b%b%b rd_a=%0d rd_b=%0d want 1010 0 0",
                               dec_vld, alu_en, mul_en, shf_en, rd_a, rd_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (rf_we !== 3'b000) begin n_fail++; $display("FAIL mul_nowb: got %b want 000", rf_we); end
        end
    endtask

    task automatic test_compare();
        idle(4);
        in_vld = 1; in_instr = mk(0, 0, 0, 5, 3, 1, 2);
        tick();
        in_instr = mk(0, 0, 0, 0, 6, 3, 3);
        tick();
        in_vld = 0;
        n_tests++;
        if ({obs_rdy, dec_vld, rd_a, rf_we} !== {1'b1, 1'b1, 4'd3, 3'b000}) begin
            n_fail++; $display("FAIL cmp_nostall: got rdy=%b vld=%b rd_a=%0d we=%b want 1 1 3 000",
                               obs_rdy, dec_vld, rd_a, rf_we);
        end
        tick();
        n_tests++;
        if ({rf_we, rf_wa} !== {3'b001, 4'd6}) begin
            n_fail++; $display("FAIL cmp_next_wb: got we=%b wa=%0d want 001 6", rf_we, rf_wa);
        end
    endtask

    task automatic test_flush();
        idle(4);
        in_vld = 1; in_instr = mk(2, 1, 0, 2, 7, 1, 2);
        tick();
        flush = 1; in_instr = mk(0, 0, 0, 0, 8, 9, 10);
        tick();
        n_tests++;
        if ({obs_rdy, dec_vld, rf_we, rf_wa} !== {1'b0, 1'b0, 3'b100, 4'd7}) begin
            n_fail++; $display("FAIL flush: got rdy=%b vld=%b we=%b wa=%0d want 0 0 100 7",
                               obs_rdy, dec_vld, rf_we, rf_wa);
        end
        flush = 0; in_vld = 0;
        tick();
        n_tests++;
        if ({dec_vld, shf_en, cls, subop, rf_we} !== {1'b0, 1'b1, 2'd1, 4'd2, 3'b000}) begin
            n_fail++; $display("FAIL flush_hold: got vld=%b shf=%b cls=%0d subop=%0d we=%b want 0 1 1 2 000",
                               dec_vld, shf_en, cls, subop, rf_we);
        end
    endtask

    task automatic test_noop();
        idle(4);
        in_vld = 1; in_float = 1; in_instr = mk(3, 2, 1, 9, 4, 5, 6);
        tick();
        in_vld = 0; in_float = 0;
        n_tests++;
        if ({dec_vld, alu_en, mul_en, shf_en, cu_float, cls, rd_a, rd_b} !== {5'b10001, 2'd2, 8'd0}) begin
            n_fail++; $display("FAIL noop_dec: got %h want %h", {dec_vld, alu_en, mul_en, shf_en, cu_float, cls, rd_a, rd_b},
                               {5'b10001, 2'd2, 8'd0});
        end
        tick(); tick();
        n_tests++;
        if (obs_vec() !== exp_vec() || rf_we !== 3'b000) begin
            n_fail++; $display("FAIL noop_nowb: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset();
        idle(4);
        in_vld = 1; in_instr = mk(0, 0, 0, 0, 1, 2, 3);
        tick();
        in_instr = mk(2, 0, 0, 0, 4, 5, 6);
        tick();
        in_vld = 0;
        #2; rst = 1; #1;
        model_clear();
        n_tests++;
        if (obs_vec() !== 29'd0) begin n_fail++; $display("FAIL reset_async: got %h want 0", obs_vec()); end
        @(posedge clk); cyc++;
        #2; rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (rf_we !== 3'b000 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_after: got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_vld   = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            in_float = 1'($urandom_range(0, 1));
            in_instr = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                          $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            tick();
            n_tests++;
            if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", i, obs_vec(), exp_vec()); end
        end
        idle(2);
    endtask

    initial begin
        test_reset_state();
        test_alu();
        test_dependent();
        test_mul_noread();
        test_compare();
        test_flush();
        test_noop();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
